// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD initiator and bus responder:
// opcodes, timing defaults, controller state encoding and error flag indices.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;

  localparam int unsigned E_MIN_HIGH_DEF   = 12;
  localparam int unsigned CMD_BUSY_DEF     = 2000;
  localparam int unsigned CLEAR_BUSY_DEF   = 82000;
  localparam int unsigned POWERUP_WAIT_DEF = 750000;

  localparam int unsigned SHADOW_DEPTH = 32;
  localparam logic [7:0]  FILL_CHAR    = 8'h20;

  localparam int unsigned ERR_SHORT_E = 0;
  localparam int unsigned ERR_BUSY    = 1;
  localparam int unsigned ERR_EARLY   = 2;
  localparam int unsigned ERR_ILLEGAL = 3;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    PWRUP = 3'd1,
    FS1   = 3'd2,
    FS2   = 3'd3,
    FS3   = 3'd4,
    READY = 3'd5,
    CLEAR = 3'd6
  } lcd_state_t;

  // Visible DDRAM positions are 0x00-0x0F (line 0) and 0x40-0x4F (line 1).
  function automatic logic addr_valid(input logic [6:0] a);
    return a[5:4] == 2'b00;
  endfunction

  // Step within a line, wrapping line 0 end <-> line 1 start in both directions.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a[3:0] == 4'hF) return {~a[6], 6'h00};
      else                return a + 7'd1;
    end else begin
      if (a[3:0] == 4'h0) return {~a[6], 2'b00, 4'hF};
      else                return a - 7'd1;
    end
  endfunction

  function automatic logic [4:0] shadow_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

endpackage

// File: rtl/lcd_bus_responder_ddram_shadow.sv
// 32x8 DDRAM shadow: one synchronous write port, one registered read port.
module lcd_ddram_shadow
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [SHADOW_DEPTH];

  // Array contents are initialised by the controller's fill sequence, not by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// Responder for the 8-bit character-LCD bus: checks protocol and timing,
// decodes commands/data and maintains a 2x16 DDRAM shadow.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned E_MIN_HIGH   = E_MIN_HIGH_DEF,
  parameter int unsigned CMD_BUSY     = CMD_BUSY_DEF,
  parameter int unsigned CLEAR_BUSY   = CLEAR_BUSY_DEF,
  parameter int unsigned POWERUP_WAIT = POWERUP_WAIT_DEF
) (
  input  logic       CLK_50MHZ,
  input  logic       BTN_SOUTH,
  input  logic [7:0] LCD_DB,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic [6:0] CUR_ADDR,
  output logic       EVT_VALID,
  output logic       EVT_RS,
  output logic [7:0] EVT_DATA,
  output logic       BUSY,
  output logic       INIT_DONE,
  output logic [3:0] ERR,
  output logic [7:0] LED
);

  localparam int unsigned EW   = $clog2(E_MIN_HIGH + 1);
  localparam int unsigned PW   = $clog2(POWERUP_WAIT + 1);
  localparam int unsigned BMAX = (CLEAR_BUSY > CMD_BUSY) ? CLEAR_BUSY : CMD_BUSY;
  localparam int unsigned BW   = $clog2(BMAX + 1);

  logic           clk, rst;
  logic [10:0]    sync1, sync2;
  logic [7:0]     db_s;
  logic           e_s, rs_s, rw_s, e_prev;
  logic           e_rise, e_fall, wr;
  logic [EW-1:0]  e_cnt;
  logic [PW-1:0]  pwr_cnt;
  logic           pwr_done;
  logic [BW-1:0]  busy_cnt, busy_val;
  logic           busy_load;
  logic [4:0]     fill_idx;
  logic [3:0]     err, err_set;
  logic [6:0]     cur_addr, addr_n;
  logic           id, id_n;
  logic           mem_we;
  logic [4:0]     mem_waddr;
  logic [7:0]     mem_wdata;
  lcd_state_t     state, state_n;
  logic [2:0]     state_bits;

  assign clk = CLK_50MHZ;
  assign rst = BTN_SOUTH;

  assign {db_s, e_s, rs_s, rw_s} = sync2;
  assign e_rise   = e_s & ~e_prev;
  assign e_fall   = ~e_s & e_prev;
  assign wr       = e_fall & ~rw_s;
  assign pwr_done = (pwr_cnt == PW'(POWERUP_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    err_set   = '0;
    addr_n    = cur_addr;
    id_n      = id;
    mem_we    = 1'b0;
    mem_waddr = fill_idx;
    mem_wdata = FILL_CHAR;
    busy_load = 1'b0;
    busy_val  = BW'(CMD_BUSY);

    unique case (state)
      FILL: begin
        mem_we = 1'b1;
        if (fill_idx == 5'(SHADOW_DEPTH - 1)) state_n = PWRUP;
      end
      CLEAR: begin
        mem_we = 1'b1;
        if (fill_idx == 5'(SHADOW_DEPTH - 1)) state_n = READY;
      end
      PWRUP: if (pwr_done) state_n = FS1;
      default: ;
    endcase

    // Bus-level checks apply to every write outside FILL; decode depends on state.
    if (wr && state != FILL) begin
      if (e_cnt < EW'(E_MIN_HIGH)) err_set[ERR_SHORT_E] = 1'b1;
      if (!pwr_done) begin
        err_set[ERR_EARLY] = 1'b1;
      end else begin
        busy_load = 1'b1;
        if (busy_cnt != '0) err_set[ERR_BUSY] = 1'b1;
        if (!rs_s && db_s[7:2] == 6'd0 && db_s[1:0] != 2'd0) busy_val = BW'(CLEAR_BUSY);

        if (rs_s) begin
          if (state == READY) begin
            mem_we    = 1'b1;
            mem_waddr = shadow_index(cur_addr);
            mem_wdata = db_s;
            addr_n    = addr_step(cur_addr, id);
          end else begin
            err_set[ERR_ILLEGAL] = 1'b1;
          end
        end else begin
          unique case (state)
            FS1, FS2, FS3: begin
              if (db_s[7:4] == 4'h3) begin
                if (state == FS1)      state_n = FS2;
                else if (state == FS2) state_n = FS3;
                else                   state_n = READY;
              end else begin
                err_set[ERR_ILLEGAL] = 1'b1;
              end
            end
            READY: begin
              casez (db_s)
                8'b1???????: begin
                  if (addr_valid(db_s[6:0])) addr_n = db_s[6:0];
                  else                       err_set[ERR_ILLEGAL] = 1'b1;
                end
                8'b01??????: ;
                8'b001?????: ;
                8'b0001????: addr_n = addr_step(cur_addr, db_s[2]);
                8'b00001???: ;
                8'b000001??: id_n = db_s[1];
                8'b0000001?: addr_n = '0;
                8'b00000001: begin
                  addr_n  = '0;
                  state_n = CLEAR;
                end
                default: err_set[ERR_ILLEGAL] = 1'b1;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      e_prev    <= 1'b0;
      e_cnt     <= '0;
      pwr_cnt   <= '0;
      busy_cnt  <= '0;
      fill_idx  <= '0;
      err       <= '0;
      cur_addr  <= '0;
      id        <= 1'b1;
      EVT_VALID <= 1'b0;
      EVT_RS    <= 1'b0;
      EVT_DATA  <= '0;
    end else begin
      sync1  <= {LCD_DB, LCD_E, LCD_RS, LCD_RW};
      sync2  <= sync1;
      e_prev <= e_s;
      // Starting at 1 on the rise makes the count equal the number of high clocks.
      if (e_rise)                                 e_cnt <= EW'(1);
      else if (e_s && e_cnt != EW'(E_MIN_HIGH))  e_cnt <= e_cnt + EW'(1);
      if (!pwr_done) pwr_cnt <= pwr_cnt + PW'(1);
      if (busy_load)            busy_cnt <= busy_val;
      else if (busy_cnt != '0)  busy_cnt <= busy_cnt - BW'(1);
      if (state == FILL || state == CLEAR) fill_idx <= fill_idx + 5'd1;
      else                                 fill_idx <= '0;
      err       <= err | err_set;
      cur_addr  <= addr_n;
      id        <= id_n;
      EVT_VALID <= e_fall;
      if (e_fall) begin
        EVT_RS   <= rs_s;
        EVT_DATA <= db_s;
      end
    end
  end

  lcd_ddram_shadow u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (RD_ADDR),
    .rdata (RD_CHAR)
  );

  assign state_bits = state;
  assign CUR_ADDR   = cur_addr;
  assign BUSY       = (busy_cnt != '0);
  assign INIT_DONE  = (state == READY);
  assign ERR        = err;
  assign LED        = {err, INIT_DONE, state_bits};

endmodule
